// File: rtl/axil_sram_arbiter_ctrl.sv
// AXI4-Lite slave for the scratchpad SRAM window: round-robin read/write arbitration
// onto a single-port synchronous SRAM, one transaction in flight at a time.
module axil_sram_arbiter_ctrl #(
  parameter int unsigned AXI_ADDR_BW_p = 16,
  parameter int unsigned AXI_DATA_BW_p = 32,
  parameter int unsigned SRAM_DEPTH_p  = 4096,
  parameter logic [AXI_ADDR_BW_p-1:0] BASE_ADDR_p = AXI_ADDR_BW_p'('h4000)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [AXI_ADDR_BW_p-1:0]          s_awaddr_i,
  input  logic                              s_awvalid_i,
  output logic                              s_awready_o,
  input  logic [AXI_DATA_BW_p-1:0]          s_wdata_i,
  input  logic [AXI_DATA_BW_p/8-1:0]        s_wstrb_i,
  input  logic                              s_wvalid_i,
  output logic                              s_wready_o,
  output logic [1:0]                        s_bresp_o,
  output logic                              s_bvalid_o,
  input  logic                              s_bready_i,
  input  logic [AXI_ADDR_BW_p-1:0]          s_araddr_i,
  input  logic                              s_arvalid_i,
  output logic                              s_arready_o,
  output logic [AXI_DATA_BW_p-1:0]          s_rdata_o,
  output logic [1:0]                        s_rresp_o,
  output logic                              s_rvalid_o,
  input  logic                              s_rready_i,
  output logic                              sram_en_o,
  output logic [AXI_DATA_BW_p/8-1:0]        sram_we_o,
  output logic [$clog2(SRAM_DEPTH_p)-1:0]   sram_addr_o,
  output logic [AXI_DATA_BW_p-1:0]          sram_wdata_o,
  input  logic [AXI_DATA_BW_p-1:0]          sram_rdata_i
);

  localparam int unsigned AW = $clog2(SRAM_DEPTH_p);
  localparam logic [AXI_ADDR_BW_p:0] WIN_BYTES = (AXI_ADDR_BW_p+1)'(SRAM_DEPTH_p * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WRESP, ST_RD, ST_RCAP, ST_RRESP
  } state_t;

  state_t state;
  logic   last_wr;
  logic   err_q;

  logic                     wr_req, rd_req;
  logic                     grant_wr, grant_rd;
  logic [AXI_ADDR_BW_p-1:0] req_addr, req_off;
  logic                     req_err;

  // Arbitration and window decode of the granted channel's address
  always_comb begin
    wr_req   = s_awvalid_i && s_wvalid_i;
    rd_req   = s_arvalid_i;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == ST_IDLE) begin
      if (wr_req && rd_req) begin
        grant_wr = !last_wr;
        grant_rd = last_wr;
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end
    end
    req_addr = grant_wr ? s_awaddr_i : s_araddr_i;
    req_off  = req_addr - BASE_ADDR_p;
    req_err  = {1'b0, req_off} >= WIN_BYTES;
  end

  assign s_awready_o = grant_wr;
  assign s_wready_o  = grant_wr;
  assign s_arready_o = grant_rd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      last_wr      <= 1'b1;
      err_q        <= 1'b0;
      sram_en_o    <= 1'b0;
      sram_we_o    <= '0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      s_bvalid_o   <= 1'b0;
      s_bresp_o    <= RESP_OKAY;
      s_rvalid_o   <= 1'b0;
      s_rresp_o    <= RESP_OKAY;
      s_rdata_o    <= '0;
    end else begin
      // SRAM strobes are single-cycle pulses
      sram_en_o <= 1'b0;
      sram_we_o <= '0;
      unique case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            sram_en_o    <= !req_err;
            sram_we_o    <= req_err ? '0 : s_wstrb_i;
            sram_addr_o  <= req_off[AW+1:2];
            sram_wdata_o <= s_wdata_i;
            err_q        <= req_err;
            last_wr      <= 1'b1;
            state        <= ST_WR;
          end else if (grant_rd) begin
            sram_en_o   <= !req_err;
            sram_addr_o <= req_off[AW+1:2];
            err_q       <= req_err;
            last_wr     <= 1'b0;
            state       <= ST_RD;
          end
        end
        ST_WR: begin
          s_bvalid_o <= 1'b1;
          s_bresp_o  <= err_q ? RESP_SLVERR : RESP_OKAY;
          state      <= ST_WRESP;
        end
        ST_WRESP: begin
          if (s_bready_i) begin
            s_bvalid_o <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_RD: state <= ST_RCAP;
        ST_RCAP: begin
          s_rdata_o  <= err_q ? '0 : sram_rdata_i;
          s_rvalid_o <= 1'b1;
          s_rresp_o  <= err_q ? RESP_SLVERR : RESP_OKAY;
          state      <= ST_RRESP;
        end
        ST_RRESP: begin
          if (s_rready_i) begin
            s_rvalid_o <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sram_arbiter_ctrl.sv
// Scoreboard bench for axil_sram_arbiter_ctrl: directed scenarios plus randomized
// concurrent read/write traffic against a word-array reference model.
module tb_axil_sram_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] s_awaddr_i, s_araddr_i;
  logic        s_awvalid_i, s_wvalid_i, s_arvalid_i, s_bready_i, s_rready_i;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic        s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o;
  logic [1:0]  s_bresp_o, s_rresp_o;
  logic [31:0] s_rdata_o, sram_wdata_o, sram_rdata_i;
  logic        sram_en_o;
  logic [3:0]  sram_we_o;
  logic [11:0] sram_addr_o;

  axil_sram_arbiter_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] resp; logic [31:0] data; int cyc; } rsp_t;
  typedef struct { logic [11:0] addr; logic [3:0] we; logic [31:0] wdata; int cyc; } sop_t;

  rsp_t b_q[$], r_q[$];
  sop_t s_q[$];
  byte  grant_log[$];

  bit [31:0] mem [4096];      // SRAM macro behaviour
  bit [31:0] ref_mem [4096];  // reference model contents
  int  cyc;
  bit  rst_q;
  int  n_pass, n_total;
  bit  rand_rdy, hold_b;
  bit  b_seen, r_seen;
  int  b_hs_cyc;
  bit  model_last_wr = 1'b1;

  function automatic void chk(bit ok, string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Window decode from the address map, in plain integer arithmetic
  function automatic void decode(input logic [15:0] a, output bit err, output logic [11:0] idx);
    int unsigned ua = a;
    err = (ua < 32'h4000) || (ua >= 32'h4000 + 4096 * 4);
    idx = err ? 12'd0 : 12'((ua - 32'h4000) / 4);
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_i;
    if (sram_en_o) begin
      sram_rdata_i <= mem[sram_addr_o];
      for (int b = 0; b < 4; b++)
        if (sram_we_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
    end
  end

  // Response handshakes; bready is forced low while hold_b is set
  initial begin
    s_bready_i = 1'b1;
    s_rready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        s_bready_i = ($urandom_range(0, 3) != 0);
        s_rready_i = ($urandom_range(0, 3) != 0);
      end else begin
        s_bready_i = !hold_b;
        s_rready_i = 1'b1;
      end
    end
  end

  // Monitor: pops expected B/R/SRAM events and compares as the DUT presents them
  always @(negedge clk) begin
    rsp_t e;
    sop_t s;
    if (rst_q) begin
      b_q.delete(); r_q.delete();
      b_seen = 0; r_seen = 0;
      chk(!sram_en_o, "sram_en_after_reset", 32'(sram_en_o), 0);
    end
    if (s_bvalid_o && !b_seen) begin
      b_seen = 1;
      if (b_q.size() == 0) chk(0, "b_unexpected", 32'(s_bresp_o), 0);
      else chk(cyc == b_q[0].cyc, "b_latency", 32'(cyc), 32'(b_q[0].cyc));
    end
    if (s_bvalid_o && s_bready_i && b_q.size() > 0) begin
      e = b_q.pop_front();
      chk(s_bresp_o == e.resp, "bresp", 32'(s_bresp_o), 32'(e.resp));
      b_seen = 0;
      b_hs_cyc = cyc;
    end
    if (s_rvalid_o && !r_seen) begin
      r_seen = 1;
      if (r_q.size() == 0) chk(0, "r_unexpected", s_rdata_o, 0);
      else chk(cyc == r_q[0].cyc, "r_latency", 32'(cyc), 32'(r_q[0].cyc));
    end
    if (s_rvalid_o && s_rready_i && r_q.size() > 0) begin
      e = r_q.pop_front();
      chk(s_rresp_o == e.resp, "rresp", 32'(s_rresp_o), 32'(e.resp));
      chk(s_rdata_o == e.data, "rdata", s_rdata_o, e.data);
      r_seen = 0;
    end
    if (sram_en_o) begin
      if (s_q.size() == 0) chk(0, "sram_unexpected", 32'(sram_addr_o), 0);
      else begin
        s = s_q.pop_front();
        chk(cyc == s.cyc, "sram_latency", 32'(cyc), 32'(s.cyc));
        chk(sram_addr_o == s.addr, "sram_addr", 32'(sram_addr_o), 32'(s.addr));
        chk(sram_we_o == s.we, "sram_we", 32'(sram_we_o), 32'(s.we));
        if (s.we != 0) chk(sram_wdata_o == s.wdata, "sram_wdata", sram_wdata_o, s.wdata);
      end
    end
  end

  // Arbitration rule: contended grant goes opposite the previous grant
  always @(negedge clk) begin
    bit wr_req, rd_req, exp_wr, exp_rd;
    if (rst_q) model_last_wr = 1'b1;
    if (!rst_i && (s_awready_o || s_wready_o || s_arready_o)) begin
      wr_req = s_awvalid_i && s_wvalid_i;
      rd_req = s_arvalid_i;
      exp_wr = wr_req && (!rd_req || !model_last_wr);
      exp_rd = rd_req && !exp_wr;
      chk({s_awready_o, s_wready_o, s_arready_o} == {exp_wr, exp_wr, exp_rd}, "arb_grant",
          32'({s_awready_o, s_wready_o, s_arready_o}), 32'({exp_wr, exp_wr, exp_rd}));
      model_last_wr = exp_wr;
    end
    if (s_bvalid_o || s_rvalid_o)
      chk(!(s_awready_o || s_arready_o), "ready_while_busy",
          32'({s_awready_o, s_arready_o}), 0);
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int wdly);
    bit err, ok;
    logic [11:0] idx;
    int n = 0;
    @(posedge clk); #1;
    s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
    s_awvalid_i = 1'b1; s_wvalid_i = (wdly == 0);
    ok = 0;
    forever begin
      @(negedge clk);
      if (s_awready_o) begin ok = 1; break; end
      n++;
      if (n > 300) break;
      @(posedge clk); #1;
      if (n >= wdly) s_wvalid_i = 1'b1;
    end
    if (!ok) chk(0, "aw_timeout", 32'(a), 0);
    else begin
      decode(a, err, idx);
      if (!err) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        s_q.push_back('{idx, s, d, cyc + 1});
      end
      b_q.push_back('{err ? 2'b10 : 2'b00, 32'h0, cyc + 2});
      grant_log.push_back("W");
      @(posedge clk); #1;
    end
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output int acc);
    bit err, ok;
    logic [11:0] idx;
    int n = 0;
    @(posedge clk); #1;
    s_araddr_i = a; s_arvalid_i = 1'b1;
    ok = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (s_arready_o) begin ok = 1; break; end
      n++;
      if (n > 300) break;
    end
    if (!ok) chk(0, "ar_timeout", 32'(a), 0);
    else begin
      acc = cyc;
      decode(a, err, idx);
      if (!err) s_q.push_back('{idx, 4'h0, 32'h0, cyc + 1});
      r_q.push_back('{err ? 2'b10 : 2'b00, err ? 32'h0 : ref_mem[idx], cyc + 3});
      grant_log.push_back("R");
      @(posedge clk); #1;
    end
    s_arvalid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() + r_q.size() + s_q.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk((b_q.size() + r_q.size() + s_q.size()) == 0, "drain",
        32'(b_q.size() + r_q.size() + s_q.size()), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned r = $urandom_range(0, 15);
    if (r == 0) return 16'h8000 + 16'($urandom_range(0, 255));
    if (r == 1) return 16'h3FFC;
    if (r == 2) return 16'h7FFC + 16'($urandom_range(0, 3));
    return 16'h4000 + 16'($urandom_range(0, 15) * 4) + 16'($urandom_range(0, 3));
  endfunction

  initial begin
    int racc;
    byte exp_g;
    rst_i = 1'b1;
    s_awaddr_i = '0; s_araddr_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
    s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk(!s_awready_o && !s_wready_o && !s_arready_o, "rst_readies",
        32'({s_awready_o, s_wready_o, s_arready_o}), 0);
    chk(!s_bvalid_o && !s_rvalid_o, "rst_valids", 32'({s_bvalid_o, s_rvalid_o}), 0);
    chk(!sram_en_o && sram_we_o == 0, "rst_sram", 32'({sram_en_o, sram_we_o}), 0);
    chk(s_rdata_o == 0, "rst_rdata", s_rdata_o, 0);
    chk(s_bresp_o == 0 && s_rresp_o == 0, "rst_resp", 32'({s_bresp_o, s_rresp_o}), 0);

    // full-word write then readback; byte-lane overwrite then readback
    do_write(16'h4010, 32'hDEADBEEF, 4'hF, 0);
    do_read(16'h4010, racc);
    do_write(16'h4010, 32'h0000AB00, 4'b0010, 0);
    do_read(16'h4010, racc);
    drain();
    chk(ref_mem[4] == 32'hDEADABEF, "model_merge", ref_mem[4], 32'hDEADABEF);

    // contention straight after reset alternates R,W,R,W
    pulse_reset();
    grant_log.delete();
    repeat (3) fork
      do_write(16'h4020, $urandom, 4'hF, 0);
      do_read(16'h4020, racc);
    join
    drain();
    chk(grant_log.size() == 6, "contend_count", 32'(grant_log.size()), 6);
    foreach (grant_log[i]) begin
      exp_g = (i % 2 == 0) ? "R" : "W";
      chk(grant_log[i] == exp_g, "contend_order", 32'(grant_log[i]), 32'(exp_g));
    end

    // AW without W is not a request; the read is served first
    grant_log.delete();
    fork
      do_write(16'h4024, 32'h12345678, 4'hF, 6);
      do_read(16'h4010, racc);
    join
    drain();
    chk(grant_log.size() == 2 && grant_log[0] == "R", "aw_no_w_order",
        32'(grant_log.size()), 2);

    // stalled B response blocks AR until bready
    hold_b = 1'b1;
    @(posedge clk); #2;
    do_write(16'h4030, 32'hCAFEF00D, 4'hF, 0);
    fork
      do_read(16'h4030, racc);
      begin
        int n = 0;
        while (!s_bvalid_o && n < 20) begin @(negedge clk); n++; end
        repeat (5) begin
          @(negedge clk);
          chk(s_bvalid_o, "bhold_bvalid", 32'(s_bvalid_o), 1);
          chk(!s_arready_o, "bhold_arready", 32'(s_arready_o), 0);
        end
        hold_b = 1'b0;
      end
    join
    chk(racc == b_hs_cyc + 1, "ar_after_b", 32'(racc), 32'(b_hs_cyc + 1));
    drain();

    // out-of-window read and zero-strobe write
    do_read(16'h8000, racc);
    do_write(16'h4034, 32'hFFFFFFFF, 4'h0, 0);
    do_read(16'h4034, racc);
    drain();

    // reset while in RD: the read response is dropped
    do_read(16'h4010, racc);
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk(!s_rvalid_o, "rst_rd_rvalid", 32'(s_rvalid_o), 0);
    end
    do_read(16'h4010, racc);
    drain();

    // randomized concurrent traffic with random response back-pressure
    rand_rdy = 1'b1;
    fork
      repeat (60) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end
      repeat (60) begin
        int acc;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_read(rand_addr(), acc);
      end
    join
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
